// File: rtl/shift_rotate_reg.sv
// Universal shift/rotate register: single-step per enabled clock, or a
// multi-cycle shift-by-N command with busy/done handshake.
module shift_rotate_reg #(
  parameter int DW = 8,
  parameter int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          sync_rst_n,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic          en,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          ser_in,
  output logic [DW-1:0] q,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [1:0]    mode_q, mode_d;
  logic          done_q, done_d;

  // One step of the register; dir 0 moves toward the MSB.
  function automatic logic [DW-1:0] step_fn(
    input logic [DW-1:0] v,
    input logic          d,
    input logic [1:0]    m,
    input logic          s
  );
    logic          fill;
    logic [DW-1:0] res;
    fill = 1'b0;
    if (!d) begin
      case (m)
        2'b00:   fill = v[DW-1];
        2'b11:   fill = s;
        default: fill = 1'b0;
      endcase
      res = {v[DW-2:0], fill};
    end else begin
      case (m)
        2'b00:   fill = v[0];
        2'b10:   fill = v[DW-1];
        2'b11:   fill = s;
        default: fill = 1'b0;
      endcase
      res = {fill, v[DW-1:1]};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (load) begin
      q_d     = data;
      state_d = IDLE;
    end else if (state_q == RUN) begin
      q_d   = step_fn(q_q, dir_q, mode_q, ser_in);
      cnt_d = cnt_q - AW'(1);
      if (cnt_q == AW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      dir_d  = dir;
      mode_d = mode;
      cnt_d  = amt;
      // A zero-length command completes immediately without entering RUN.
      if (amt == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (en) begin
      q_d = step_fn(q_q, dir, mode, ser_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign ser_out = ((state_q == RUN) ? dir_q : dir) ? q_q[0] : q_q[DW-1];

endmodule

// File: tb/tb_shift_rotate_reg.sv
// Self-checking bench for shift_rotate_reg (DW = 8): directed scenarios plus
// randomized traffic compared against a cycle-level arithmetic model.
module tb_shift_rotate_reg;

  logic       clk = 1'b0;
  logic       sync_rst_n = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [2:0] amt = 3'd0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic       ser_out, busy, done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_q = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  int         m_rem = 0;
  logic       m_ldir = 1'b0;
  logic [1:0] m_lmode = 2'b00;

  shift_rotate_reg #(.DW(8)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .load(load), .data(data), .en(en),
    .start(start), .amt(amt), .dir(dir), .mode(mode), .ser_in(ser_in),
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Step expressed with plain shift arithmetic.
  function automatic logic [7:0] m_step(input logic [7:0] v, input logic d,
                                        input logic [1:0] md, input logic s);
    logic [7:0] r;
    logic [7:0] top;
    top = {s, 7'b0};
    case ({d, md})
      3'b000:  r = (v << 1) | (v >> 7);
      3'b100:  r = (v >> 1) | (v << 7);
      3'b001,
      3'b010:  r = v << 1;
      3'b101:  r = v >> 1;
      3'b110:  r = 8'($signed(v) >>> 1);
      3'b011:  r = (v << 1) | {7'b0, s};
      default: r = (v >> 1) | top;
    endcase
    return r;
  endfunction

  task automatic m_update();
    logic n_done;
    if (!sync_rst_n) begin
      m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      m_ldir = 1'b0; m_lmode = 2'b00;
    end else begin
      n_done = 1'b0;
      if (load) begin
        m_q = data; m_busy = 1'b0;
      end else if (m_busy) begin
        m_q = m_step(m_q, m_ldir, m_lmode, ser_in);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_busy = 1'b0; n_done = 1'b1; end
      end else if (start) begin
        m_ldir = dir; m_lmode = mode; m_rem = int'(amt);
        if (amt == 3'd0) n_done = 1'b1; else m_busy = 1'b1;
      end else if (en) begin
        m_q = m_step(m_q, dir, mode, ser_in);
      end
      m_done = n_done;
    end
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1; data = d;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst_n = 1'b0; load = 1'b1; data = 8'hFF;
    tick();
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    sync_rst_n = 1'b1; load = 1'b0; data = 8'h00;
  endtask

  task automatic test_rotate_cmd();
    logic [7:0] exp_q [3] = '{8'h4B, 8'h96, 8'h2D};
    do_load(8'hA5);
    dir = 1'b0; mode = 2'b00; amt = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (q !== 8'hA5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rot_start: got q=%h busy=%b expected q=a5 busy=1", q, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("[TB] FAIL rot_step%0d: got %h expected %h", i + 1, q, exp_q[i]); end
      checks++; if (busy !== (i < 2) || done !== (i == 2)) begin
        errors++; $display("[TB] FAIL rot_hs%0d: got busy=%b done=%b expected busy=%b done=%b", i + 1, busy, done, i < 2, i == 2);
      end
    end
    checks++; if (ser_out !== 1'b0) begin errors++; $display("[TB] FAIL rot_ser_out: got %b expected 0", ser_out); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rot_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_right_shifts();
    logic [1:0] modes [3] = '{2'b10, 2'b01, 2'b11};
    logic [7:0] e1 [3] = '{8'hC8, 8'h48, 8'hC8};
    logic [7:0] e2 [3] = '{8'hE4, 8'h24, 8'hE4};
    ser_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_load(8'h90);
      mode = modes[k]; dir = 1'b1; amt = 3'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++; if (q !== e1[k]) begin errors++; $display("[TB] FAIL right_m%0d_s1: got %h expected %h", modes[k], q, e1[k]); end
      tick();
      checks++; if (q !== e2[k] || done !== 1'b1) begin
        errors++; $display("[TB] FAIL right_m%0d_s2: got q=%h done=%b expected q=%h done=1", modes[k], q, done, e2[k]);
      end
    end
    ser_in = 1'b0;
  endtask

  task automatic test_abort_zero();
    do_load(8'h5A);
    dir = 1'b0; mode = 2'b00; amt = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    load = 1'b1; data = 8'h3C;
    tick();
    load = 1'b0;
    checks++; if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort: got q=%h busy=%b done=%b expected q=3c busy=0 done=0", q, busy, done);
    end
    tick();
    checks++; if (done !== 1'b0 || q !== 8'h3C) begin errors++; $display("[TB] FAIL abort_nodone: got q=%h done=%b expected q=3c done=0", q, done); end
    amt = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_amt: got q=%h busy=%b done=%b expected q=3c busy=0 done=1", q, busy, done);
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_amt_after: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_idle_step_lockout();
    logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
    int n;
    en = 1'b1; dir = 1'b0; mode = 2'b00;
    do_load(8'h81);
    checks++; if (q !== 8'h81) begin errors++; $display("[TB] FAIL idle_load: got %h expected 81", q); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i] || done !== 1'b0) begin
        errors++; $display("[TB] FAIL idle_step%0d: got q=%h done=%b expected q=%h done=0", i, q, done, exp_q[i]);
      end
    end
    en = 1'b0;
    do_load(8'h01);
    amt = 3'd4; start = 1'b1;
    tick();
    n = 0;
    en = 1'b1; dir = 1'b1; mode = 2'b01; amt = 3'd1;
    tick(); n++;
    tick(); n++;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lockout_busy: got %b expected 1", busy); end
    start = 1'b0; en = 1'b0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (done !== 1'b1 || n != 4) begin errors++; $display("[TB] FAIL lockout_steps: got done=%b steps=%0d expected done=1 steps=4", done, n); end
    checks++; if (q !== 8'h10) begin errors++; $display("[TB] FAIL lockout_q: got %h expected 10", q); end
    dir = 1'b0; mode = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_load(8'hC3);
    dir = 1'b0; mode = 2'b00; amt = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    sync_rst_n = 1'b0;
    tick();
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid: got q=%h busy=%b done=%b expected 00 0 0", q, busy, done);
    end
    sync_rst_n = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_after: got busy=%b done=%b expected 0 0", busy, done); end
    do_load(8'h01);
    dir = 1'b1; amt = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (q !== 8'h40 || done !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_new: got q=%h done=%b expected q=40 done=1", q, done); end
    dir = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_load(8'h11);
    dir = 1'b0; mode = 2'b00; amt = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (q !== 8'h22 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_first: got q=%h busy=%b done=%b expected 22 0 1", q, busy, done);
    end
    start = 1'b1; amt = 3'd2; dir = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    checks++; if (q !== 8'h22 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_accept: got q=%h busy=%b done=%b expected 22 1 0", q, busy, done);
    end
    tick();
    tick();
    checks++; if (q !== 8'h08 || done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got q=%h done=%b expected 08 1", q, done); end
  endtask

  task automatic test_random();
    logic exp_so;
    for (int i = 0; i < 400; i++) begin
      sync_rst_n = ($urandom_range(0, 59) != 0);
      load   = ($urandom_range(0, 19) == 0);
      data   = 8'($urandom);
      en     = 1'($urandom);
      start  = ($urandom_range(0, 3) == 0);
      amt    = 3'($urandom);
      dir    = 1'($urandom);
      mode   = 2'($urandom);
      ser_in = 1'($urandom);
      tick();
      exp_so = (m_busy ? m_ldir : dir) ? m_q[0] : m_q[7];
      checks++; if (q !== m_q || busy !== m_busy || done !== m_done || ser_out !== exp_so) begin
        errors++;
        $display("[TB] FAIL rand%0d: got q=%h busy=%b done=%b so=%b expected q=%h busy=%b done=%b so=%b",
                 i, q, busy, done, ser_out, m_q, m_busy, m_done, exp_so);
      end
    end
    sync_rst_n = 1'b1; load = 1'b0; en = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotate_cmd();
    test_right_shifts();
    test_abort_zero();
    test_idle_step_lockout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
